// File: rtl/mem_xfer_unit.sv
// Memory transfer unit: owns MAR/MDR and runs the request/MFC handshake with a
// wait-state timeout, sized byte-lane accesses, read extension and endianness.
module mem_xfer_unit #(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int BIG_ENDIAN = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Rw,
    input  logic [1:0]        Size,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] Addr_in,
    input  logic [31:0]       Wdata_in,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        Fault,
    output logic [31:0]       Rdata_out,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [31:0]       Mem_wdata,
    output logic [3:0]        Mem_be,
    output logic              Mem_en,
    output logic              Mem_rw,
    input  logic [31:0]       Mem_rdata,
    input  logic              Mem_mfc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_TMO   = 2'b10;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t             state_r;
    logic [7:0]         wait_cnt_r;
    logic [1:0]         size_r;
    logic               signed_r;
    logic               busy_r;
    logic               done_r;
    logic [1:0]         fault_r;
    logic [31:0]        rdata_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [31:0]        mem_wdata_r;
    logic [3:0]         mem_be_r;
    logic               mem_en_r;
    logic               mem_rw_r;
    logic               start_legal_s;

    // Physical byte lane for a byte address; big-endian mirrors the index.
    function automatic logic [1:0] byte_lane(input logic [1:0] a);
        if (BIG_ENDIAN != 0) begin
            byte_lane = 2'd3 - a;
        end else begin
            byte_lane = a;
        end
    endfunction

    function automatic logic half_lane(input logic a);
        if (BIG_ENDIAN != 0) begin
            half_lane = ~a;
        end else begin
            half_lane = a;
        end
    endfunction

    function automatic logic access_legal(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: access_legal = 1'b1;
            SZ_HALF: access_legal = ~a[0];
            SZ_WORD: access_legal = (a == 2'b00);
            default: access_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: calc_be = 4'b0001 << byte_lane(a);
            SZ_HALF: calc_be = half_lane(a[1]) ? 4'b1100 : 4'b0011;
            SZ_WORD: calc_be = 4'b1111;
            default: calc_be = 4'b0000;
        endcase
    endfunction

    // Store data goes out on every lane so the RAM only needs the enables.
    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: replicate = {4{d[7:0]}};
            SZ_HALF: replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] sz, input logic [1:0] a,
                                            input logic sgn, input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        case (byte_lane(a))
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            2'd3:    b = raw[31:24];
            default: b = 8'h00;
        endcase
        h = half_lane(a[1]) ? raw[31:16] : raw[15:0];
        case (sz)
            SZ_BYTE: extract = {{24{sgn & b[7]}}, b};
            SZ_HALF: extract = {{16{sgn & h[15]}}, h};
            default: extract = raw;
        endcase
    endfunction

    assign start_legal_s = access_legal(Size, Addr_in[1:0]);

    // Transfer sequencer: latches MAR/MDR and drives every output from a register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 8'd0;
            size_r      <= 2'b00;
            signed_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= FLT_OK;
            rdata_r     <= 32'd0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'd0;
            mem_be_r    <= 4'b0000;
            mem_en_r    <= 1'b0;
            mem_rw_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        mem_addr_r  <= Addr_in;
                        mem_rw_r    <= Rw;
                        size_r      <= Size;
                        signed_r    <= Signed;
                        mem_wdata_r <= replicate(Size, Wdata_in);
                        wait_cnt_r  <= 8'd0;
                        if (start_legal_s) begin
                            state_r  <= REQ;
                            fault_r  <= FLT_OK;
                            busy_r   <= 1'b1;
                            mem_en_r <= 1'b1;
                            mem_be_r <= calc_be(Size, Addr_in[1:0]);
                        end else begin
                            state_r <= DONE;
                            fault_r <= FLT_ALIGN;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // Completion wins over timeout when both land on the same edge.
                    if (Mem_mfc) begin
                        state_r  <= DONE;
                        fault_r  <= FLT_OK;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        mem_en_r <= 1'b0;
                        mem_be_r <= 4'b0000;
                        if (!mem_rw_r) begin
                            rdata_r <= extract(size_r, mem_addr_r[1:0], signed_r, Mem_rdata);
                        end else begin
                            rdata_r <= rdata_r;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r  <= DONE;
                        fault_r  <= FLT_TMO;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        mem_en_r <= 1'b0;
                        mem_be_r <= 4'b0000;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    mem_en_r <= 1'b0;
                    mem_be_r <= 4'b0000;
                end
            endcase
        end
    end

    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Fault     = fault_r;
    assign Rdata_out = rdata_r;
    assign Mem_addr  = mem_addr_r;
    assign Mem_wdata = mem_wdata_r;
    assign Mem_be    = mem_be_r;
    assign Mem_en    = mem_en_r;
    assign Mem_rw    = mem_rw_r;

endmodule

// File: tb/tb_mem_xfer_unit.sv
// Bench for mem_xfer_unit: little- and big-endian instances share stimulus and are
// checked against an arithmetic reference model of the transfer rules.
module tb_mem_xfer_unit;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        Rw;
    logic [1:0]  Size;
    logic        Signed;
    logic [31:0] Addr_in;
    logic [31:0] Wdata_in;
    logic [31:0] Mem_rdata;
    logic        Mem_mfc;

    logic        l_busy, l_done, l_en, l_rw;
    logic [1:0]  l_fault;
    logic [31:0] l_rdata, l_addr, l_wdata;
    logic [3:0]  l_be;
    logic        b_busy, b_done, b_en, b_rw;
    logic [1:0]  b_fault;
    logic [31:0] b_rdata, b_addr, b_wdata;
    logic [3:0]  b_be;

    int checks = 0;
    int errors = 0;

    // observations of the most recent transfer
    int          obs_en, obs_done_cyc;
    bit          obs_done, obs_busy_ok, obs_done_low;
    logic [3:0]  obs_be_l, obs_be_b;
    logic [31:0] obs_wd_l, obs_rd_l, obs_rd_b, obs_addr;
    logic [1:0]  obs_flt_l, obs_flt_b;
    logic        obs_rw;

    // model of the read-data register of each instance
    logic [31:0] m_rd_l, m_rd_b;

    always #5 clk = ~clk;

    mem_xfer_unit #(.ADDR_W(32), .TIMEOUT(15), .BIG_ENDIAN(0)) u_le (
        .Clk(clk), .Reset_n(Reset_n), .Start(Start), .Rw(Rw), .Size(Size), .Signed(Signed),
        .Addr_in(Addr_in), .Wdata_in(Wdata_in), .Busy(l_busy), .Done(l_done), .Fault(l_fault),
        .Rdata_out(l_rdata), .Mem_addr(l_addr), .Mem_wdata(l_wdata), .Mem_be(l_be),
        .Mem_en(l_en), .Mem_rw(l_rw), .Mem_rdata(Mem_rdata), .Mem_mfc(Mem_mfc));

    mem_xfer_unit #(.ADDR_W(32), .TIMEOUT(15), .BIG_ENDIAN(1)) u_be (
        .Clk(clk), .Reset_n(Reset_n), .Start(Start), .Rw(Rw), .Size(Size), .Signed(Signed),
        .Addr_in(Addr_in), .Wdata_in(Wdata_in), .Busy(b_busy), .Done(b_done), .Fault(b_fault),
        .Rdata_out(b_rdata), .Mem_addr(b_addr), .Mem_wdata(b_wdata), .Mem_be(b_be),
        .Mem_en(b_en), .Mem_rw(b_rw), .Mem_rdata(Mem_rdata), .Mem_mfc(Mem_mfc));

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return 1'b1;
        if (size == 2'd1) return (addr % 32'd2) == 32'd0;
        if (size == 2'd2) return (addr % 32'd4) == 32'd0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr, input bit big);
        int lane;
        if (size == 2'd0) begin
            lane = int'(addr % 32'd4);
            if (big) lane = 3 - lane;
            return 4'(1 << lane);
        end
        if (size == 2'd1) begin
            lane = int'((addr / 32'd2) % 32'd2);
            if (big) lane = 1 - lane;
            return (lane == 1) ? 4'hC : 4'h3;
        end
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_extract(input logic [1:0] size, input logic [31:0] addr,
                                              input bit sgn, input logic [31:0] raw, input bit big);
        int lane;
        logic [31:0] v;
        if (size == 2'd0) begin
            lane = int'(addr % 32'd4);
            if (big) lane = 3 - lane;
            v = (raw >> (8 * lane)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (size == 2'd1) begin
            lane = int'((addr / 32'd2) % 32'd2);
            if (big) lane = 1 - lane;
            v = (raw >> (16 * lane)) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
            return v;
        end
        return raw;
    endfunction

    task automatic model_commit(input logic rw, input logic [1:0] size, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] raw, input int delay);
        if (m_legal(size, addr) && !rw && delay >= 0 && delay < 15) begin
            m_rd_l = m_extract(size, addr, sgn, raw, 1'b0);
            m_rd_b = m_extract(size, addr, sgn, raw, 1'b1);
        end
    endtask

    // ---------------- stimulus driver ----------------
    // mfc_delay: REQ cycles without Mem_mfc before it is raised (-1 = never).
    task automatic run_xfer(input logic rw, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] raw, input int mfc_delay, input bit hammer);
        int cyc;
        obs_en = 0; obs_done = 0; obs_done_cyc = -1; obs_busy_ok = 1; obs_done_low = 0;
        @(negedge clk);
        Start = 1'b1; Rw = rw; Size = size; Signed = sgn; Addr_in = addr;
        Wdata_in = wdata; Mem_rdata = raw; Mem_mfc = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        cyc = 0;
        while (!obs_done && cyc < 40) begin
            if (l_done) begin
                obs_done = 1; obs_done_cyc = cyc;
                obs_flt_l = l_fault; obs_flt_b = b_fault;
                obs_rd_l = l_rdata; obs_rd_b = b_rdata;
                obs_addr = l_addr; obs_rw = l_rw;
                Mem_mfc = 1'b0; Start = 1'b0;
            end else begin
                if (l_en) begin
                    obs_en++;
                    if (obs_en == 1) begin
                        obs_be_l = l_be; obs_be_b = b_be; obs_wd_l = l_wdata;
                    end
                    if (!l_busy || !b_en) obs_busy_ok = 0;
                end
                Mem_mfc = (mfc_delay >= 0 && l_en && obs_en == mfc_delay + 1);
                if (hammer) begin
                    Start = 1'b1;
                    Addr_in = addr ^ 32'h0000_0F04;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (obs_done) begin
            @(negedge clk);
            obs_done_low = !l_done && !l_en && !b_done;
        end else begin
            checks++; errors++;
            $display("FAIL xfer_no_done: no Done within 40 cycles (addr %h size %0d)", addr, size);
            Start = 1'b0; Mem_mfc = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset_n = 1'b0; Start = 1'b0; Rw = 1'b0; Size = 2'd0; Signed = 1'b0;
        Addr_in = 32'd0; Wdata_in = 32'd0; Mem_rdata = 32'd0; Mem_mfc = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({l_busy, l_done, l_fault, l_en, l_rw, l_be} !== 10'd0 || l_rdata !== 32'd0 ||
            l_addr !== 32'd0 || l_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_le: busy %b done %b fault %b en %b rw %b be %b rdata %h addr %h wdata %h, all must be 0",
                     l_busy, l_done, l_fault, l_en, l_rw, l_be, l_rdata, l_addr, l_wdata);
        end
        checks++;
        if ({b_busy, b_done, b_fault, b_en, b_rw, b_be} !== 10'd0 || b_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_be: busy %b done %b fault %b en %b be %b rdata %h, all must be 0",
                     b_busy, b_done, b_fault, b_en, b_be, b_rdata);
        end
        Reset_n = 1'b1;
        m_rd_l = 32'd0; m_rd_b = 32'd0;
        @(negedge clk);
        checks++;
        if (l_en !== 1'b0 || l_done !== 1'b0 || l_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: en %b done %b busy %b, required 0 0 0", l_en, l_done, l_busy);
        end
    endtask

    task automatic test_word_read();
        run_xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        model_commit(1'b0, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 0);
        checks++;
        if (obs_en !== 1 || obs_done_cyc !== 1 || obs_be_l !== 4'hF) begin
            errors++;
            $display("FAIL word_read_timing: en_cycles %0d done_at %0d be %b, required 1 1 1111",
                     obs_en, obs_done_cyc, obs_be_l);
        end
        checks++;
        if (obs_rd_l !== 32'hDEAD_BEEF || obs_rd_b !== 32'hDEAD_BEEF || obs_flt_l !== 2'b00) begin
            errors++;
            $display("FAIL word_read_data: rdata %h/%h fault %b, required deadbeef 00",
                     obs_rd_l, obs_rd_b, obs_flt_l);
        end
        checks++;
        if (!obs_done_low) begin
            errors++;
            $display("FAIL word_read_done_pulse: Done still high after 1 cycle, required one-cycle pulse");
        end
    endtask

    task automatic test_byte_read();
        run_xfer(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 0, 0);
        model_commit(1'b0, 2'b00, 1'b1, 32'h103, 32'h8012_3456, 0);
        checks++;
        if (obs_be_l !== 4'b1000 || obs_rd_l !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL byte_signed_le: be %b rdata %h, required 1000 ffffff80", obs_be_l, obs_rd_l);
        end
        checks++;
        if (obs_be_b !== 4'b0001 || obs_rd_b !== 32'h0000_0056) begin
            errors++;
            $display("FAIL byte_signed_be: be %b rdata %h, required 0001 00000056", obs_be_b, obs_rd_b);
        end
        run_xfer(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 0, 0);
        model_commit(1'b0, 2'b00, 1'b0, 32'h103, 32'h8012_3456, 0);
        checks++;
        if (obs_rd_l !== 32'h0000_0080) begin
            errors++;
            $display("FAIL byte_unsigned_le: rdata %h, required 00000080", obs_rd_l);
        end
    endtask

    task automatic test_half_write();
        run_xfer(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 32'h1234_5678, 3, 0);
        model_commit(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_5678, 3);
        checks++;
        if (obs_wd_l !== 32'hABCD_ABCD || obs_be_l !== 4'b1100 || obs_be_b !== 4'b0011 || obs_rw !== 1'b1) begin
            errors++;
            $display("FAIL half_write_bus: wdata %h be %b/%b rw %b, required abcdabcd 1100/0011 1",
                     obs_wd_l, obs_be_l, obs_be_b, obs_rw);
        end
        checks++;
        if (obs_en !== 4 || obs_done_cyc !== 4 || obs_flt_l !== 2'b00 || obs_rd_l !== m_rd_l) begin
            errors++;
            $display("FAIL half_write_done: en_cycles %0d done_at %0d fault %b rdata %h, required 4 4 00 %h",
                     obs_en, obs_done_cyc, obs_flt_l, obs_rd_l, m_rd_l);
        end
    endtask

    task automatic test_misaligned();
        run_xfer(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h5555_AAAA, 0, 0);
        checks++;
        if (obs_en !== 0 || obs_done_cyc !== 0 || obs_flt_l !== 2'b01 || obs_rd_l !== m_rd_l) begin
            errors++;
            $display("FAIL misaligned_word: en_cycles %0d done_at %0d fault %b rdata %h, required 0 0 01 %h",
                     obs_en, obs_done_cyc, obs_flt_l, obs_rd_l, m_rd_l);
        end
        run_xfer(1'b1, 2'b11, 1'b0, 32'h200, 32'h0, 32'h0, 0, 0);
        checks++;
        if (obs_en !== 0 || obs_done_cyc !== 0 || obs_flt_l !== 2'b01 || obs_flt_b !== 2'b01) begin
            errors++;
            $display("FAIL reserved_size: en_cycles %0d done_at %0d fault %b/%b, required 0 0 01/01",
                     obs_en, obs_done_cyc, obs_flt_l, obs_flt_b);
        end
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, -1, 0);
        checks++;
        if (obs_en !== 15 || obs_flt_l !== 2'b10 || obs_rd_l !== m_rd_l || obs_rd_b !== m_rd_b) begin
            errors++;
            $display("FAIL timeout_fault: en_cycles %0d fault %b rdata %h, required 15 10 %h",
                     obs_en, obs_flt_l, obs_rd_l, m_rd_l);
        end
        run_xfer(1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h1357_9BDF, 14, 0);
        model_commit(1'b0, 2'b10, 1'b0, 32'h304, 32'h1357_9BDF, 14);
        checks++;
        if (obs_en !== 15 || obs_flt_l !== 2'b00 || obs_rd_l !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL timeout_edge_mfc: en_cycles %0d fault %b rdata %h, required 15 00 13579bdf",
                     obs_en, obs_flt_l, obs_rd_l);
        end
    endtask

    task automatic test_ignore_start();
        run_xfer(1'b0, 2'b01, 1'b1, 32'h4002, 32'h0, 32'hC3A5_0000, 2, 1);
        model_commit(1'b0, 2'b01, 1'b1, 32'h4002, 32'hC3A5_0000, 2);
        checks++;
        if (obs_addr !== 32'h4002 || obs_en !== 3 || obs_rd_l !== 32'hFFFF_C3A5 || !obs_done_low) begin
            errors++;
            $display("FAIL start_ignored: addr %h en_cycles %0d rdata %h done_low %0d, required 4002 3 ffffc3a5 1",
                     obs_addr, obs_en, obs_rd_l, obs_done_low);
        end
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        Start = 1'b1; Rw = 1'b0; Size = 2'b10; Signed = 1'b0; Addr_in = 32'h40; Mem_mfc = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (l_en !== 1'b1 || l_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_active: en %b busy %b, required 1 1", l_en, l_busy);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (l_en !== 1'b0 || l_busy !== 1'b0 || l_done !== 1'b0 || b_en !== 1'b0 || l_addr !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_drop: en %b busy %b done %b be_en %b addr %h, required 0 0 0 0 0",
                     l_en, l_busy, l_done, b_en, l_addr);
        end
        @(negedge clk);
        Reset_n = 1'b1;
        m_rd_l = 32'd0; m_rd_b = 32'd0;
        run_xfer(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 1, 0);
        model_commit(1'b0, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D, 1);
        checks++;
        if (obs_en !== 2 || obs_flt_l !== 2'b00 || obs_rd_l !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL after_reset_xfer: en_cycles %0d fault %b rdata %h, required 2 00 cafef00d",
                     obs_en, obs_flt_l, obs_rd_l);
        end
    endtask

    task automatic test_random();
        logic        rw, sgn;
        logic [1:0]  size;
        logic [31:0] addr, wd, raw;
        int          dly, r, exp_en;
        bit          legal, ok;
        logic [1:0]  exp_flt;
        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = $urandom(); wd = $urandom(); raw = $urandom();
            r = int'($urandom_range(0, 9));
            dly = (r == 0) ? -1 : (r == 1) ? 14 : int'($urandom_range(0, 4));
            legal = m_legal(size, addr);
            ok = legal && dly >= 0 && dly < 15;
            exp_en = !legal ? 0 : ok ? dly + 1 : 15;
            exp_flt = !legal ? 2'b01 : ok ? 2'b00 : 2'b10;
            run_xfer(rw, size, sgn, addr, wd, raw, dly, 0);
            model_commit(rw, size, sgn, addr, raw, dly);
            checks++;
            if (obs_en !== exp_en || obs_done_cyc !== exp_en || !obs_done_low || !obs_busy_ok) begin
                errors++;
                $display("FAIL rand_timing[%0d]: en_cycles %0d done_at %0d done_low %0d busy_ok %0d, required %0d %0d 1 1",
                         n, obs_en, obs_done_cyc, obs_done_low, obs_busy_ok, exp_en, exp_en);
            end
            checks++;
            if (obs_flt_l !== exp_flt || obs_flt_b !== exp_flt || obs_addr !== addr || obs_rw !== rw) begin
                errors++;
                $display("FAIL rand_status[%0d]: fault %b/%b addr %h rw %b, required %b %h %b",
                         n, obs_flt_l, obs_flt_b, obs_addr, obs_rw, exp_flt, addr, rw);
            end
            checks++;
            if (obs_rd_l !== m_rd_l || obs_rd_b !== m_rd_b) begin
                errors++;
                $display("FAIL rand_rdata[%0d]: rdata %h/%h, required %h/%h", n, obs_rd_l, obs_rd_b, m_rd_l, m_rd_b);
            end
            if (legal) begin
                checks++;
                if (obs_be_l !== m_be(size, addr, 1'b0) || obs_be_b !== m_be(size, addr, 1'b1) ||
                    obs_wd_l !== m_wdata(size, wd)) begin
                    errors++;
                    $display("FAIL rand_lanes[%0d]: be %b/%b wdata %h, required %b/%b %h", n, obs_be_l, obs_be_b,
                             obs_wd_l, m_be(size, addr, 1'b0), m_be(size, addr, 1'b1), m_wdata(size, wd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_read();
        test_half_write();
        test_misaligned();
        test_timeout();
        test_ignore_start();
        test_reset_mid_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
